param_register_file: RTL
========================

Name: param_register_file

Overview:
- Next-generation CPU register file with parameterised data width and register count.
- Provides three combinational read ports (A, B, D), one write port (C/PW), and a dedicated program-counter register with load or auto-increment.
- Adds an optional same-cycle write-to-read bypass, an optional hard-wired zero register, and a pending-write scoreboard with per-port hazard flags.
- Sits between decode (read/issue) and writeback in the pipelined datapath; feeds the hazard unit.

Parameters:
DATA_W, 32, width of every register and data port
NUM_REGS, 16, number of architectural registers including PC; must be a power of two, minimum 4
PC_IDX, NUM_REGS-1, index of the register that acts as the program counter
PC_INC, 4, auto-increment step added to PC
RESET_PC, 0, PC value after reset
BYPASS, 1, 1 = a read of the register being written this cycle returns PW
ZERO_R0, 0, 1 = register 0 reads as 0, ignores writes, never goes busy

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  reset, asynchronous, active-low
SA  in  AW  read select, port A (AW = log2(NUM_REGS))
SB  in  AW  read select, port B
SD  in  AW  read select, port D
PA  out  DATA_W  read data, port A
PB  out  DATA_W  read data, port B
PD  out  DATA_W  read data, port D
C  in  AW  write destination index
PW  in  DATA_W  write data
RFLd  in  1  write enable
PCin  in  DATA_W  external PC value
PCLd  in  1  load PC from PCin
PC_EN  in  1  auto-increment PC
PCout  out  DATA_W  current PC register value
ISS_V  in  1  issue valid; marks ISS_RD as pending write
ISS_RD  in  AW  destination of the issued instruction
HAZ_A  out  1  port A reads a pending register
HAZ_B  out  1  port B reads a pending register
HAZ_D  out  1  port D reads a pending register
BUSY  out  NUM_REGS  scoreboard vector

Behaviour:
- Reset (RST_N=0, asynchronous):
  - All general-purpose registers = 0.
  - PC = RESET_PC.
  - BUSY = 0.
  - All outputs then follow from this state; no edge is required.
- Write, on rising edge, when RFLd=1 and C != PC_IDX: reg[C] <= PW.
  - Ignored when ZERO_R0=1 and C=0.
- PC update, evaluated each edge in priority order:
  1. RFLd=1 and C=PC_IDX: PC <= PW.
  2. PCLd=1: PC <= PCin.
  3. PC_EN=1: PC <= PC + PC_INC, modulo 2^DATA_W; wraps silently.
  4. Otherwise PC holds.
- Reads are combinational with zero latency. Px = reg[Sx]; Sx=PC_IDX returns PC.
  - If BYPASS=1 and RFLd=1 and C=Sx (including PC_IDX), Px = PW.
  - If ZERO_R0=1 and Sx=0, Px = 0 regardless of bypass.
- PCout = PC register value. Not bypassed.
- Scoreboard, on rising edge:
  - Set: ISS_V=1 sets BUSY[ISS_RD].
  - Clear: RFLd=1 clears BUSY[C].
  - Set and clear on the same index in the same cycle: set wins, so BUSY stays 1 (the newer issue supersedes).
  - Set and clear on different indices in the same cycle: both take effect.
  - ISS_RD=0 with ZERO_R0=1: ignored.
  - Issue to an already-busy register: BUSY stays 1 (no counting).
- Hazards, combinational: HAZ_x = BUSY[Sx] AND NOT (BYPASS AND RFLd AND C=Sx). Forced 0 when ZERO_R0=1 and Sx=0.
- Reset asserted mid-operation: pending state is discarded, BUSY clears immediately, and in-flight writes are lost.
- Width rules: no sign extension; all data is DATA_W wide, unsigned.

Test Plan:
- Reset: hold RST_N=0 with RFLd=1, C=3, PW=0xAA across an edge -> no write; PA=0 for SA=3; PCout=RESET_PC=0; BUSY=0.
- Write then read: RFLd=1, C=5, PW=73 at one edge; then RFLd=0, SA=SB=SD=5 -> PA=PB=PD=73. Next, RFLd=1, C=5, PW=99 with SA=5 before the edge -> PA=99 (bypass) and reg[5] still 73 until the edge.
- PC priority: PC=8, PC_EN=1 -> PCout=12. Then PCLd=1, PCin=100 -> 100. Then RFLd=1, C=15, PW=200, PCLd=1, PCin=300 -> 200. PC=0xFFFFFFFC with PC_EN=1 -> 0.
- Scoreboard: ISS_V=1, ISS_RD=7 -> BUSY[7]=1; SA=7 gives HAZ_A=1. Next cycle RFLd=1, C=7 with SA=7 -> HAZ_A=0 via bypass, and BUSY[7]=0 after the edge. Same-edge ISS_V=1, ISS_RD=7 with RFLd=1, C=7 -> BUSY[7]=1.
- ZERO_R0=1 variant: write C=0, PW=5 and issue ISS_RD=0 -> PA=0 for SA=0, HAZ_A=0, BUSY[0]=0.
- Mid-operation reset: BUSY=0x00A0, PC=40; pulse RST_N low between edges -> BUSY=0 and PCout=0 immediately, without a clock edge.

Source files
------------

// File: rtl/param_register_file_if.sv
// Bundle of the register-file bus signals: read selects and data, the write port, PC control
// and the issue scoreboard.
//   master : decode/writeback side (drives selects, write data, PC control, issue)
//   slave  : register file (returns read data, PC, hazard flags, busy vector)
interface param_register_file_if #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 16
);
   localparam int unsigned AW = $clog2(NUM_REGS);

   logic [AW-1:0]       sa;
   logic [AW-1:0]       sb;
   logic [AW-1:0]       sd;
   logic [DATA_W-1:0]   pa;
   logic [DATA_W-1:0]   pb;
   logic [DATA_W-1:0]   pd;
   logic [AW-1:0]       c;
   logic [DATA_W-1:0]   pw;
   logic                rfld;
   logic [DATA_W-1:0]   pcin;
   logic                pcld;
   logic                pc_en;
   logic [DATA_W-1:0]   pcout;
   logic                iss_v;
   logic [AW-1:0]       iss_rd;
   logic                haz_a;
   logic                haz_b;
   logic                haz_d;
   logic [NUM_REGS-1:0] busy;

   modport master (
      output sa, sb, sd, c, pw, rfld, pcin, pcld, pc_en, iss_v, iss_rd,
      input  pa, pb, pd, pcout, haz_a, haz_b, haz_d, busy
   );

   modport slave (
      input  sa, sb, sd, c, pw, rfld, pcin, pcld, pc_en, iss_v, iss_rd,
      output pa, pb, pd, pcout, haz_a, haz_b, haz_d, busy
   );
endinterface

// File: rtl/param_register_file.sv
// Parameterised CPU register file: three combinational read ports (A, B, D), one write port,
// a program counter held in register PC_IDX (write / load / auto-increment), optional
// write-to-read bypass, optional hard-wired zero register and a pending-write scoreboard.
// Ports:
//   i_clk   : clock, all state updates on the rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : slave side of param_register_file_if (selects, data, PC control, scoreboard)
module param_register_file #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       NUM_REGS = 16,
   parameter int unsigned       PC_IDX   = NUM_REGS - 1,
   parameter int unsigned       PC_INC   = 4,
   parameter logic [DATA_W-1:0] RESET_PC = '0,
   parameter bit                BYPASS   = 1'b1,
   parameter bit                ZERO_R0  = 1'b0
) (
   input logic                 i_clk,
   input logic                 i_rst_n,
   param_register_file_if.slave io_bus
);
   localparam int unsigned AW = $clog2(NUM_REGS);

   // PC lives in r_regs[PC_IDX] so a plain indexed read returns it.
   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_busy;

   logic [DATA_W-1:0]   w_pc_d;
   logic [NUM_REGS-1:0] w_busy_d;
   logic [NUM_REGS-1:0] w_we;

   logic [AW-1:0]       w_c;
   logic [DATA_W-1:0]   w_pw;
   logic                w_rfld;

   assign w_c    = io_bus.c;
   assign w_pw   = io_bus.pw;
   assign w_rfld = io_bus.rfld;

   // Read one port: bypass from the write port, then force zero for r0 if enabled.
   function automatic logic [DATA_W-1:0] f_read(input logic [AW-1:0] sel);
      logic [DATA_W-1:0] v;
      v = r_regs[sel];
      if (BYPASS && w_rfld && (w_c == sel)) v = w_pw;
      if (ZERO_R0 && (sel == '0)) v = '0;
      return v;
   endfunction

   // A register being written this cycle is no longer a hazard when bypass is on.
   function automatic logic f_haz(input logic [AW-1:0] sel);
      logic h;
      h = r_busy[sel] && !(BYPASS && w_rfld && (w_c == sel));
      if (ZERO_R0 && (sel == '0)) h = 1'b0;
      return h;
   endfunction

   // General-purpose write enables; PC index and (optionally) r0 never take the plain write.
   always_comb begin
      w_we = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         w_we[i] = w_rfld && (w_c == AW'(i)) && (i != PC_IDX) && !(ZERO_R0 && (i == 0));
      end
   end

   // PC next state in priority order: write port, external load, auto-increment, hold.
   always_comb begin
      w_pc_d = r_regs[PC_IDX];
      if (w_rfld && (w_c == AW'(PC_IDX))) begin
         w_pc_d = w_pw;
      end else if (io_bus.pcld) begin
         w_pc_d = io_bus.pcin;
      end else if (io_bus.pc_en) begin
         w_pc_d = r_regs[PC_IDX] + DATA_W'(PC_INC);
      end
   end

   // Clear before set so a same-index issue and writeback leaves the bit set.
   always_comb begin
      w_busy_d = r_busy;
      if (w_rfld) w_busy_d[w_c] = 1'b0;
      if (io_bus.iss_v && !(ZERO_R0 && (io_bus.iss_rd == '0))) begin
         w_busy_d[io_bus.iss_rd] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= (i == PC_IDX) ? RESET_PC : '0;
         end
         r_busy <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (i == PC_IDX) begin
               r_regs[i] <= w_pc_d;
            end else if (w_we[i]) begin
               r_regs[i] <= w_pw;
            end
         end
         r_busy <= w_busy_d;
      end
   end

   always_comb begin
      io_bus.pa    = f_read(io_bus.sa);
      io_bus.pb    = f_read(io_bus.sb);
      io_bus.pd    = f_read(io_bus.sd);
      io_bus.haz_a = f_haz(io_bus.sa);
      io_bus.haz_b = f_haz(io_bus.sb);
      io_bus.haz_d = f_haz(io_bus.sd);
      io_bus.pcout = r_regs[PC_IDX];
      io_bus.busy  = r_busy;
   end
endmodule
